// File: rtl/branch_ckpt_ctrl.sv
// Branch-checkpoint scheduler: allocates one of SLOTS checkpoint slots per branch.
// Out-of-order resolutions are replayed to the register file in program order.
module branch_ckpt_ctrl #(
    parameter int SLOTS = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            brIssueEn,
    output logic [PTRW-1:0] brIssueTag,
    output logic            full,
    input  logic            resEn,
    input  logic [PTRW-1:0] resTag,
    input  logic            resMis,
    output logic            branchDeeper,
    output logic            bFreeEn,
    output logic            misTaken,
    output logic [PTRW-1:0] outstanding
);

    typedef enum logic [1:0] {
        ST_PEND = 2'd0,
        ST_OK   = 2'd1,
        ST_MIS  = 2'd2
    } status_e;

    localparam logic [PTRW-1:0] MAX_LIVE = PTRW'(SLOTS - 1);
    localparam logic [PTRW-1:0] ONE      = PTRW'(1);
    localparam logic [PTRW-1:0] ZERO     = PTRW'(0);

    logic [PTRW-1:0]        head_q, head_d;
    logic [PTRW-1:0]        tail_q, tail_d;
    logic [PTRW-1:0]        count_q, count_d;
    logic [SLOTS-1:0][1:0]  status_q, status_d;

    logic                   live_s;
    logic                   retire_ok_s;
    logic                   retire_mis_s;
    logic                   issue_s;
    logic                   res_acc_s;
    logic [PTRW-1:0]        res_off_s;

    assign full        = (count_q == MAX_LIVE);
    assign brIssueTag  = tail_q;
    assign outstanding = count_q;

    // Retire decision from registered state, then issue/resolve acceptance and next state
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        status_d = status_q;

        live_s       = (count_q != ZERO);
        retire_ok_s  = rdy && live_s && (status_q[head_q] == ST_OK);
        retire_mis_s = rdy && live_s && (status_q[head_q] == ST_MIS);
        issue_s      = rdy && brIssueEn && !full && !retire_mis_s;
        // Offset from head wraps modulo SLOTS, so the live test works across the ring seam
        res_off_s    = resTag - head_q;
        res_acc_s    = rdy && resEn && !retire_mis_s && (res_off_s < count_q)
                       && (status_q[resTag] == ST_PEND);

        if (retire_mis_s) begin
            tail_d  = head_q;
            count_d = ZERO;
            for (int i = 0; i < SLOTS; i++) begin
                status_d[i] = ST_PEND;
            end
        end else begin
            if (res_acc_s) begin
                status_d[resTag] = resMis ? ST_MIS : ST_OK;
            end else begin
                status_d[resTag] = status_q[resTag];
            end
            if (issue_s) begin
                status_d[tail_q] = ST_PEND;
                tail_d           = tail_q + ONE;
            end else begin
                tail_d = tail_q;
            end
            // Releasing the head slot overrides anything written to it above
            if (retire_ok_s) begin
                status_d[head_q] = ST_PEND;
                head_d           = head_q + ONE;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + (issue_s ? ONE : ZERO) - (retire_ok_s ? ONE : ZERO);
        end

        branchDeeper = issue_s;
        bFreeEn      = retire_ok_s;
        misTaken     = retire_mis_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= ZERO;
            tail_q  <= ZERO;
            count_q <= ZERO;
            for (int i = 0; i < SLOTS; i++) begin
                status_q[i] <= ST_PEND;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed bench for branch_ckpt_ctrl: issue, in-order retire, rollback, wrap, rdy and reset.
module tb_branch_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       brIssueEn;
    logic [1:0] brIssueTag;
    logic       full;
    logic       resEn;
    logic [1:0] resTag;
    logic       resMis;
    logic       branchDeeper;
    logic       bFreeEn;
    logic       misTaken;
    logic [1:0] outstanding;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_ckpt_ctrl #(.SLOTS(4), .PTRW(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .brIssueEn(brIssueEn), .brIssueTag(brIssueTag), .full(full),
        .resEn(resEn), .resTag(resTag), .resMis(resMis),
        .branchDeeper(branchDeeper), .bFreeEn(bFreeEn), .misTaken(misTaken),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #2;
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] exp_tag, input logic [1:0] exp_out);
        chk({tag, ".bd"}, 32'(branchDeeper), 32'd0);
        chk({tag, ".free"}, 32'(bFreeEn), 32'd0);
        chk({tag, ".mis"}, 32'(misTaken), 32'd0);
        chk({tag, ".tag"}, 32'(brIssueTag), 32'(exp_tag));
        chk({tag, ".out"}, 32'(outstanding), 32'(exp_out));
        chk({tag, ".full"}, 32'(full), 32'(exp_out == 2'd3));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; brIssueEn = 1'b0; resEn = 1'b0; resTag = 2'd0; resMis = 1'b0;
        #1;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        chk_idle("reset", 2'd0, 2'd0);

        // Three issues fill the ring; a fourth is refused
        cyc();
        brIssueEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("iss.bd", 32'(branchDeeper), 32'd1);
            chk("iss.tag", 32'(brIssueTag), 32'(i));
            chk("iss.full", 32'(full), 32'd0);
            cyc();
        end
        settle();
        chk("full.bd", 32'(branchDeeper), 32'd0);
        chk("full.full", 32'(full), 32'd1);
        chk("full.out", 32'(outstanding), 32'd3);
        chk("full.tag", 32'(brIssueTag), 32'd3);
        cyc();
        brIssueEn = 1'b0;

        // Reverse-order OK resolutions: nothing retires until tag 0 resolves
        resEn = 1'b1; resMis = 1'b0;
        for (int t = 2; t >= 0; t--) begin
            resTag = 2'(t);
            settle();
            chk("rev.free", 32'(bFreeEn), 32'd0);
            chk("rev.mis", 32'(misTaken), 32'd0);
            cyc();
        end
        resEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("drain.free", 32'(bFreeEn), 32'd1);
            chk("drain.out", 32'(outstanding), 32'(3 - k));
            cyc();
        end
        settle();
        chk_idle("drained", 2'd3, 2'd0);
        // Head and tail both at 3: the next issue gets tag 3
        brIssueEn = 1'b1;
        settle();
        chk("head3.bd", 32'(branchDeeper), 32'd1);
        chk("head3.tag", 32'(brIssueTag), 32'd3);
        cyc();
        brIssueEn = 1'b0;

        // Mispredict behind a correct older branch
        do_reset();
        brIssueEn = 1'b1;
        cyc(); cyc(); cyc();
        brIssueEn = 1'b0;
        resEn = 1'b1; resTag = 2'd1; resMis = 1'b1;
        settle();
        chk("mis.r1.free", 32'(bFreeEn), 32'd0);
        cyc();
        resTag = 2'd0; resMis = 1'b0;
        settle();
        chk("mis.r0.free", 32'(bFreeEn), 32'd0);
        chk("mis.r0.mis", 32'(misTaken), 32'd0);
        cyc();
        resEn = 1'b0;
        settle();
        chk("mis.c0.free", 32'(bFreeEn), 32'd1);
        chk("mis.c0.mis", 32'(misTaken), 32'd0);
        cyc();
        // Issue and resolution presented together with misTaken are dropped
        brIssueEn = 1'b1; resEn = 1'b1; resTag = 2'd2; resMis = 1'b0;
        settle();
        chk("mis.mt.mis", 32'(misTaken), 32'd1);
        chk("mis.mt.free", 32'(bFreeEn), 32'd0);
        chk("mis.mt.bd", 32'(branchDeeper), 32'd0);
        chk("mis.mt.out", 32'(outstanding), 32'd2);
        cyc();
        brIssueEn = 1'b0; resEn = 1'b0;
        settle();
        chk_idle("mis.after", 2'd1, 2'd0);
        cyc();
        settle();
        chk_idle("mis.quiet", 2'd1, 2'd0);

        // Wrap: six issue/commit pairs, issuing alongside each bFreeEn
        do_reset();
        brIssueEn = 1'b1;
        settle();
        chk("wrap.tag0", 32'(brIssueTag), 32'd0);
        cyc();
        brIssueEn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            resEn = 1'b1; resTag = 2'(i % 4); resMis = 1'b0;
            cyc();
            resEn = 1'b0;
            brIssueEn = (i < 5);
            settle();
            chk("wrap.free", 32'(bFreeEn), 32'd1);
            chk("wrap.out", 32'(outstanding), 32'd1);
            if (i < 5) begin
                chk("wrap.bd", 32'(branchDeeper), 32'd1);
                chk("wrap.tag", 32'(brIssueTag), 32'((i + 1) % 4));
            end
            cyc();
            brIssueEn = 1'b0;
            settle();
            chk("wrap.out2", 32'(outstanding), 32'(i < 5 ? 1 : 0));
        end

        // rdy low freezes state and suppresses pulses
        do_reset();
        brIssueEn = 1'b1;
        cyc(); cyc();
        brIssueEn = 1'b0;
        resEn = 1'b1; resTag = 2'd0; resMis = 1'b0;
        cyc();
        resEn = 1'b0;
        rdy = 1'b0; brIssueEn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rdy.free", 32'(bFreeEn), 32'd0);
            chk("rdy.bd", 32'(branchDeeper), 32'd0);
            chk("rdy.out", 32'(outstanding), 32'd2);
            chk("rdy.tag", 32'(brIssueTag), 32'd2);
            cyc();
        end
        rdy = 1'b1; brIssueEn = 1'b0;
        settle();
        chk("rdy.back.free", 32'(bFreeEn), 32'd1);
        cyc();
        settle();
        chk("rdy.post.free", 32'(bFreeEn), 32'd0);
        chk("rdy.post.out", 32'(outstanding), 32'd1);

        // Reset with two live branches and a resolution in flight
        brIssueEn = 1'b1;
        cyc();
        brIssueEn = 1'b0;
        settle();
        chk("prerst.out", 32'(outstanding), 32'd2);
        rst = 1'b1; resEn = 1'b1; resTag = 2'd1; resMis = 1'b1;
        cyc();
        rst = 1'b0; resEn = 1'b0;
        settle();
        chk_idle("rst", 2'd0, 2'd0);
        cyc();
        settle();
        chk_idle("rst.quiet", 2'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ckpt_ctrl.md
# branch_ckpt_ctrl

Branch-checkpoint scheduler for the renaming register file. It allocates one of four checkpoint slots per dispatched branch and drives the register file's `branchDeeper` pulse. It collects out-of-order branch resolutions and replays them strictly in program order as `bFreeEn` (commit oldest checkpoint) or `misTaken` (roll back to oldest checkpoint) pulses. It sits between the dispatcher, the branch ALU and the Regfile, and its head/tail pointers mirror every regfileLine's.

## Interface
- `SLOTS`, 4: checkpoint ring depth; must equal regfileLine depth. At most `SLOTS-1` = 3 branches are outstanding.
- `PTRW`, 2: pointer and tag width, log2(SLOTS).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; low freezes all state and forces pulse outputs to 0.
- `brIssueEn`  in  1  dispatcher presents a branch this cycle.
- `brIssueTag`  out  PTRW  slot index assigned to the presented branch (= tail).
- `full`  out  1  no free slot; dispatcher must stall the branch.
- `resEn`  in  1  branch ALU resolution valid.
- `resTag`  in  PTRW  slot of the resolved branch.
- `resMis`  in  1  1 = mispredicted, 0 = predicted correctly.
- `branchDeeper`  out  1  to Regfile: a checkpoint is taken this cycle.
- `bFreeEn`  out  1  to Regfile: oldest checkpoint is released.
- `misTaken`  out  1  to Regfile and all units: roll back and flush.
- `outstanding`  out  PTRW  number of live branches, 0..3.

## Operation
- State: `head`, `tail` (PTRW each), `count` (0..3), and per-slot `status` ∈ {PEND, OK, MIS}.
- Reset values: head=tail=count=0, all status=PEND. Outputs: `full`=0, `brIssueTag`=0, `branchDeeper`=`bFreeEn`=`misTaken`=0, `outstanding`=0.
- Issue is accepted when `rdy & brIssueEn & ~full & ~misTaken`.
  - On acceptance, `branchDeeper`=1 combinationally, `status[tail]`<=PEND, and `tail`<=tail+1 mod 4.
  - A branch presented while `full` is not accepted, and `branchDeeper` stays 0.
- `full` = (count==3). It is registered-state only; a same-cycle `bFreeEn` does not clear it early.
- Resolution is accepted when `rdy & resEn`, resTag lies in [head, tail) modulo 4, and `misTaken`=0.
  - On acceptance, `status[resTag]` <= OK or MIS.
  - Resolutions for non-live slots are ignored, as is a second resolution of an already-resolved slot.
- Retire decision is a pure function of registered state (count>0):
  - status[head]=OK: `bFreeEn`=1. At the edge, head<=head+1, status[head]<=PEND, count−=1.
  - status[head]=MIS: `misTaken`=1. At the edge, tail<=head, count<=0, all status<=PEND.
  - status[head]=PEND or count=0: no pulse.
- Younger resolved-OK branches wait behind a PEND head. Retirement is in order, at one branch per cycle.
- Count update for accepted issue plus `bFreeEn` in the same cycle: count is unchanged and both pointers advance.
- On `misTaken`, a same-cycle issue and resolution are discarded. Younger slots' statuses are dropped.
- `brIssueTag` = tail and `outstanding` = count, both continuously.
- Wrap-around: all pointer arithmetic is modulo 4. The live range test uses (resTag−head) mod 4 < count.

## Timing
- Issue → `branchDeeper`: same cycle, combinational. The checkpoint is visible to the Regfile at that edge.
- Resolve at edge N → earliest `bFreeEn`/`misTaken` in cycle N+1; they are asserted for exactly one cycle per retired branch.
- A head that is resolved in the same cycle it is being retired is not possible; resolution latency is ≥1 cycle.
- `rdy`=0: no state change. `branchDeeper`, `bFreeEn` and `misTaken` are 0. `full` and `outstanding` hold.
- `rst` mid-operation: the next cycle shows reset values, and in-flight resolutions are lost.

## Test plan
- Issue 3 branches on consecutive cycles → `brIssueTag`=0,1,2 and `branchDeeper` pulses each cycle. After the third, `full`=1 and `outstanding`=3. A fourth `brIssueEn` gives `branchDeeper`=0.
- With 3 live, resolve tag 2 OK, then 1 OK, then 0 OK → no pulse until tag 0 resolves. Then `bFreeEn` follows for 3 consecutive cycles, head ends at 3 and `outstanding`=0.
- Live tags 0,1,2. Resolve 1 MIS, then 0 OK → `bFreeEn` the cycle after tag 0 resolves, `misTaken` the cycle after that. Then head=tail=1, `outstanding`=0 and `full`=0.
- Issue asserted in the same cycle as `misTaken` → `branchDeeper`=0 and `brIssueTag` afterwards equals the old head.
- Wrap: run 6 issue/commit pairs → tags 0,1,2,3,0,1. The same-cycle issue+`bFreeEn` case keeps `outstanding` constant.
- `rdy`=0 for 2 cycles while head status=OK → no `bFreeEn`. It pulses in the first cycle after `rdy` returns. `rst` with 2 live branches → all outputs 0 the next cycle.
